// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard unit.
package hazard_pkg;

  // Forwarding mux selects for the E-stage ALU operands
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MUL/DIV occupancy tracker states
  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } mdState_t;

endpackage

// File: rtl/md_occupancy_tracker.sv
// Tracks how long the multi-cycle MUL/DIV unit stays occupied after an issue.
// The issue cycle itself is covered by the caller through MdStartE, so the
// BUSY state lasts MD_LATENCY-1 cycles after the issuing edge.
module md_occupancy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic MdStartE,
  output logic MdBusy
);

  localparam logic [7:0] START_CNT = (MD_LATENCY > 1) ? 8'(MD_LATENCY - 2) : 8'd0;

  mdState_t   state;
  mdState_t   nextState;
  logic [7:0] mdCnt;
  logic [7:0] nextCnt;

  // State and down-counter registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MD_IDLE;
      mdCnt <= 8'd0;
    end else begin
      state <= nextState;
      mdCnt <= nextCnt;
    end
  end

  // Next-state logic: an issue loads the remaining busy cycles, BUSY counts down to zero
  always_comb begin
    nextState = state;
    nextCnt   = mdCnt;
    case (state)
      MD_IDLE: begin
        if (MdStartE && (MD_LATENCY > 1)) begin
          nextState = MD_BUSY;
          nextCnt   = START_CNT;
        end
      end
      MD_BUSY: begin
        if (MdStartE) begin
          nextCnt = START_CNT;
        end else if (mdCnt != 8'd0) begin
          nextCnt = mdCnt - 8'd1;
        end else begin
          nextState = MD_IDLE;
        end
      end
      default: begin
        nextState = MD_IDLE;
        nextCnt   = 8'd0;
      end
    endcase
  end

  assign MdBusy = (state == MD_BUSY);

`ifndef SYNTHESIS
  // A new issue while busy means the stall logic upstream let something through
  always @(posedge clk) begin
    if (reset_n && (state == MD_BUSY) && MdStartE)
      $error("md_occupancy_tracker: MdStartE asserted while MUL/DIV unit busy");
  end
`endif

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: forwarding selects, load-use / branch / MUL-DIV stalls,
// and a saturating count of stalled cycles.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              BranchD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              MdStartE,
  input  logic              MdOpD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCount
);

  logic mValid;
  logic wValid;
  logic eValid;
  logic lwStall;
  logic brStall;
  logic mdStall;
  logic anyStall;

  md_occupancy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) mdTracker (
    .clk     (clk),
    .reset_n (reset_n),
    .MdStartE(MdStartE),
    .MdBusy  (MdBusy)
  );

  assign mValid = RegWriteM && (WriteRegM != '0);
  assign wValid = RegWriteW && (WriteRegW != '0);
  assign eValid = RegWriteE && (WriteRegE != '0);

  // E-stage operand forwarding, the younger M result wins over W
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (mValid && (WriteRegM == RsE))      ForwardAE = FWD_MEM;
    else if (wValid && (WriteRegW == RsE)) ForwardAE = FWD_WB;
    if (mValid && (WriteRegM == RtE))      ForwardBE = FWD_MEM;
    else if (wValid && (WriteRegW == RtE)) ForwardBE = FWD_WB;
  end

  // D-stage comparator forwarding only ever needs ALUOutM
  always_comb begin
    ForwardAD = mValid && (WriteRegM == RsD);
    ForwardBD = mValid && (WriteRegM == RtD);
  end

  // Hazard detection; all sources OR into one stall that is held off during reset
  always_comb begin
    lwStall  = MemtoRegE && eValid && ((WriteRegE == RsD) || (WriteRegE == RtD));
    brStall  = BranchD &&
               ((eValid && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                (MemtoRegM && (WriteRegM != '0) &&
                 ((WriteRegM == RsD) || (WriteRegM == RtD))));
    mdStall  = MdOpD && (MdBusy || MdStartE);
    anyStall = reset_n && (lwStall || brStall || mdStall);
    StallF   = anyStall;
    StallD   = anyStall;
    FlushE   = anyStall;
  end

  // Stall-cycle performance counter, pinned at all-ones once full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= '0;
    end else if (StallD && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc against a behavioural model.
module tb_hazard_unit_mc;

  localparam int LAT    = 8;
  localparam int CW     = 4;
  localparam int CNTMAX = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       BranchD, RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM, MdStartE, MdOpD;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;

  int checks = 0;
  int passes = 0;
  int mdLeft = 0;
  int modelCount = 0;

  hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .BranchD(BranchD),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .MdStartE(MdStartE), .MdOpD(MdOpD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] expFwdE(input logic [4:0] src);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic expFwdD(input logic [4:0] src);
    return RegWriteM && WriteRegM != 0 && WriteRegM == src;
  endfunction

  function automatic logic expStall();
    logic lw, br, md;
    lw = MemtoRegE && RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    br = BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                     (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)));
    md = MdOpD && (mdLeft > 0 || MdStartE);
    return reset_n && (lw || br || md);
  endfunction

  task automatic clearInputs();
    BranchD = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MdStartE = 0; MdOpD = 0;
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge
  task automatic tick();
    logic st;
    @(posedge clk);
    if (!reset_n) begin
      mdLeft = 0;
      modelCount = 0;
    end else begin
      st = expStall();
      if (st && modelCount < CNTMAX) modelCount++;
      if (mdLeft > 0) mdLeft--;
      else if (MdStartE && LAT > 1) mdLeft = LAT - 1;
    end
    #1;
  endtask

  task automatic pulseReset();
    clearInputs();
    reset_n = 0;
    mdLeft = 0;
    modelCount = 0;
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clearInputs();
    reset_n = 0;
    RegWriteM = 1; WriteRegM = 5; RsE = 5;
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8; MdOpD = 1; MdStartE = 1;
    @(negedge clk);
    checks++; if (StallD !== 1'b0) $display("[TB] FAIL reset_stallD: got %0b expected 0", StallD); else passes++;
    checks++; if (StallF !== 1'b0 || FlushE !== 1'b0) $display("[TB] FAIL reset_stallF_flushE: got %0b%0b expected 00", StallF, FlushE); else passes++;
    checks++; if (MdBusy !== 1'b0) $display("[TB] FAIL reset_mdbusy: got %0b expected 0", MdBusy); else passes++;
    checks++; if (StallCount !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", StallCount); else passes++;
    checks++; if (ForwardAE !== 2'b10) $display("[TB] FAIL reset_fwdAE: got %b expected 10", ForwardAE); else passes++;
    tick();
    tick();
    clearInputs();
    reset_n = 1;
    @(negedge clk);
    checks++; if (MdBusy !== 1'b0) $display("[TB] FAIL reset_release_mdbusy: got %0b expected 0", MdBusy); else passes++;
    checks++; if (StallCount !== 4'd0) $display("[TB] FAIL reset_release_count: got %0d expected 0", StallCount); else passes++;
    tick();
  endtask

  task automatic test_forward();
    clearInputs();
    RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5; RtE = 5;
    @(negedge clk);
    checks++; if (ForwardAE !== 2'b10) $display("[TB] FAIL fwd_mem_priority: got %b expected 10", ForwardAE); else passes++;
    checks++; if (ForwardBE !== 2'b10) $display("[TB] FAIL fwdB_mem_priority: got %b expected 10", ForwardBE); else passes++;
    tick();
    RegWriteM = 0;
    @(negedge clk);
    checks++; if (ForwardAE !== 2'b01) $display("[TB] FAIL fwd_wb: got %b expected 01", ForwardAE); else passes++;
    tick();
    RsE = 0; RtE = 0; RegWriteM = 1; WriteRegM = 0; WriteRegW = 0;
    @(negedge clk);
    checks++; if (ForwardAE !== 2'b00) $display("[TB] FAIL fwd_r0: got %b expected 00", ForwardAE); else passes++;
    checks++; if (ForwardAD !== 1'b0) $display("[TB] FAIL fwdD_r0: got %0b expected 0", ForwardAD); else passes++;
    tick();
  endtask

  task automatic test_load_use();
    int c0;
    clearInputs();
    c0 = modelCount;
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
    @(negedge clk);
    checks++; if ({StallF, StallD, FlushE} !== 3'b111) $display("[TB] FAIL loaduse_stall: got %b expected 111", {StallF, StallD, FlushE}); else passes++;
    tick();
    checks++; if (int'(StallCount) !== c0 + 1) $display("[TB] FAIL loaduse_count: got %0d expected %0d", StallCount, c0 + 1); else passes++;
    WriteRegE = 0; RtD = 0;
    @(negedge clk);
    checks++; if (StallD !== 1'b0) $display("[TB] FAIL loaduse_r0: got %0b expected 0", StallD); else passes++;
    tick();
  endtask

  task automatic test_branch();
    clearInputs();
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    @(negedge clk);
    checks++; if (StallD !== 1'b1) $display("[TB] FAIL branch_e: got %0b expected 1", StallD); else passes++;
    tick();
    RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; WriteRegM = 3;
    @(negedge clk);
    checks++; if (StallD !== 1'b1) $display("[TB] FAIL branch_mload: got %0b expected 1", StallD); else passes++;
    tick();
    MemtoRegM = 0; RegWriteM = 1;
    @(negedge clk);
    checks++; if (StallD !== 1'b0) $display("[TB] FAIL branch_malu_stall: got %0b expected 0", StallD); else passes++;
    checks++; if (ForwardAD !== 1'b1) $display("[TB] FAIL branch_fwdAD: got %0b expected 1", ForwardAD); else passes++;
    tick();
  endtask

  task automatic test_muldiv();
    pulseReset();
    for (int cyc = 0; cyc <= 8; cyc++) begin
      MdOpD = 1;
      MdStartE = (cyc == 0);
      @(negedge clk);
      checks++;
      if (StallD !== (cyc <= 7)) $display("[TB] FAIL md_stall c%0d: got %0b expected %0b", cyc, StallD, (cyc <= 7));
      else passes++;
      checks++;
      if (MdBusy !== (cyc >= 1 && cyc <= 7)) $display("[TB] FAIL md_busy c%0d: got %0b expected %0b", cyc, MdBusy, (cyc >= 1 && cyc <= 7));
      else passes++;
      if (cyc == 8) begin
        checks++; if (StallCount !== 4'd8) $display("[TB] FAIL md_count: got %0d expected 8", StallCount); else passes++;
      end
      tick();
    end
    clearInputs();
  endtask

  task automatic test_reset_midop();
    pulseReset();
    MdStartE = 1; MdOpD = 1;
    tick();
    MdStartE = 0;
    for (int i = 0; i < 20 && mdLeft != 4; i++) tick();
    @(negedge clk);
    checks++; if (MdBusy !== 1'b1 || mdLeft != 4) $display("[TB] FAIL midop_busy: got %0b expected 1", MdBusy); else passes++;
    reset_n = 0;
    mdLeft = 0;
    modelCount = 0;
    #1;
    checks++; if (MdBusy !== 1'b0) $display("[TB] FAIL midop_reset_busy: got %0b expected 0", MdBusy); else passes++;
    checks++; if (StallCount !== 4'd0) $display("[TB] FAIL midop_reset_count: got %0d expected 0", StallCount); else passes++;
    checks++; if (StallD !== 1'b0) $display("[TB] FAIL midop_reset_stall: got %0b expected 0", StallD); else passes++;
    tick();
    reset_n = 1;
    @(negedge clk);
    checks++; if (MdBusy !== 1'b0 || StallD !== 1'b0) $display("[TB] FAIL midop_release: got %0b%0b expected 00", MdBusy, StallD); else passes++;
    tick();
    @(negedge clk);
    checks++; if (MdBusy !== 1'b0 || StallD !== 1'b0) $display("[TB] FAIL midop_idle: got %0b%0b expected 00", MdBusy, StallD); else passes++;
    tick();
    clearInputs();
  endtask

  task automatic test_saturation();
    pulseReset();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (int'(StallCount) !== modelCount) $display("[TB] FAIL sat_count c%0d: got %0d expected %0d", i, StallCount, modelCount);
      else passes++;
      tick();
    end
    @(negedge clk);
    checks++; if (StallCount !== 4'hF) $display("[TB] FAIL sat_final: got %0d expected 15", StallCount); else passes++;
    clearInputs();
  endtask

  task automatic test_random();
    pulseReset();
    for (int i = 0; i < 400; i++) begin
      BranchD   = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = 1'($urandom_range(0, 1));
      MemtoRegM = 1'($urandom_range(0, 1));
      MdOpD     = ($urandom_range(0, 3) == 0);
      MdStartE  = (mdLeft == 0) && ($urandom_range(0, 5) == 0);
      RsD = 5'($urandom_range(0, 7)); RtD = 5'($urandom_range(0, 7));
      RsE = 5'($urandom_range(0, 7)); RtE = 5'($urandom_range(0, 7));
      WriteRegE = 5'($urandom_range(0, 7));
      WriteRegM = 5'($urandom_range(0, 7));
      WriteRegW = 5'($urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if (ForwardAE !== expFwdE(RsE) || ForwardBE !== expFwdE(RtE))
        $display("[TB] FAIL rand_fwdE c%0d: got %b/%b expected %b/%b", i, ForwardAE, ForwardBE, expFwdE(RsE), expFwdE(RtE));
      else passes++;
      checks++;
      if (ForwardAD !== expFwdD(RsD) || ForwardBD !== expFwdD(RtD))
        $display("[TB] FAIL rand_fwdD c%0d: got %b%b expected %b%b", i, ForwardAD, ForwardBD, expFwdD(RsD), expFwdD(RtD));
      else passes++;
      checks++;
      if (StallF !== expStall() || StallD !== expStall() || FlushE !== expStall())
        $display("[TB] FAIL rand_stall c%0d: got %b%b%b expected %b", i, StallF, StallD, FlushE, expStall());
      else passes++;
      checks++;
      if (MdBusy !== (mdLeft > 0)) $display("[TB] FAIL rand_busy c%0d: got %0b expected %0b", i, MdBusy, (mdLeft > 0));
      else passes++;
      checks++;
      if (int'(StallCount) !== modelCount) $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", i, StallCount, modelCount);
      else passes++;
      tick();
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_muldiv();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
